hit_map_ctrl: RTL and testbench
===============================

HIT_MAP_CTRL -- requirements
Module: hit_map_ctrl

Interface
REQ-001 SHALL have parameter SHIP_CELLS, default 17, meaning the total ship cells on a board; game_over asserts when this many hits are recorded.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is on posedge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port clear_board, input, 1 bit: single-cycle pulse that starts a board wipe.
REQ-005 SHALL have ports shot_valid (input, 1), shot_ready (output, 1), shot_x (input, 4) and shot_y (input, 4): shot request handshake and target column/row.
REQ-006 SHALL have ports ship_query_xy (output, 7) and ship_present (input, 1): ship-map lookup, with ship_present valid 1 cycle after ship_query_xy is driven.
REQ-007 SHALL have ports res_valid (output, 1), res_hit (output, 1), res_dup (output, 1) and res_err (output, 1): shot result pulse and its flags.
REQ-008 SHALL have ports rd_xy (input, 7) and rd_line (input, 5): render read address, cell index y*10+x, and glyph row.
REQ-009 SHALL have port hit_pixels, output, 32 bits: registered glyph row made of 16 two-bit pixel pairs, where a pair of 11 is a marked pixel.
REQ-010 SHALL have ports hit_count (output, 7) and game_over (output, 1): number of recorded hits and the all-sunk flag.

Function
REQ-011 SHALL store 100 cells of 2 bits each, with encoding 00 = untouched, 01 = miss, 11 = hit.
REQ-012 SHALL implement an FSM with states CLEAR, IDLE, LOOKUP and UPDATE.
REQ-013 CLEAR SHALL write 00 to one cell per cycle for indices 0..99, then go to IDLE, taking exactly 100 cycles; it SHALL zero hit_count on entry.
REQ-014 shot_ready SHALL be 1 only in IDLE.
REQ-015 In IDLE, on shot_valid&shot_ready, the block SHALL capture shot_x and shot_y and go to LOOKUP.
REQ-016 A captured shot with shot_x>9 or shot_y>9 SHALL go straight to UPDATE with res_err=1, write no cell, and leave hit_count unchanged.
REQ-017 LOOKUP SHALL drive ship_query_xy = y*10+x for one cycle, then go to UPDATE; ship_query_xy SHALL be 0 in all other states.
REQ-018 UPDATE SHALL pulse res_valid for exactly 1 cycle and return to IDLE.
REQ-019 In UPDATE, if the cell is not 00, the block SHALL set res_dup=1, res_hit = (cell==11), and write nothing.
REQ-020 In UPDATE, if the cell is 00 and ship_present=1, the block SHALL write 11, set res_hit=1 and increment hit_count; hit_count SHALL saturate at 127.
REQ-021 In UPDATE, if the cell is 00 and ship_present=0, the block SHALL write 01 and set res_hit=0.
REQ-022 res_hit, res_dup and res_err SHALL be 0 whenever res_valid=0.
REQ-023 game_over SHALL be registered as (hit_count >= SHIP_CELLS).
REQ-024 Shot-to-result latency SHALL be 2 cycles after the handshake, or 1 cycle for an error shot; back-to-back shots SHALL be accepted no faster than one per 3 cycles.
REQ-025 The read port SHALL be independent of the FSM: hit_pixels updates 1 cycle after rd_xy/rd_line, every cycle, in all states.
REQ-026 The read port SHALL use only rd_line[3:0] as the glyph row r (0..15).
REQ-027 For a hit cell, hit_pixels row r SHALL be an X: pair bits [31-2r:30-2r] and [2r+1:2r] set, all others 0.
REQ-028 For a miss cell, rows 6..9 SHALL have bits [17:14] set and all other rows SHALL be 0.
REQ-029 For an untouched cell, or for rd_xy>99, hit_pixels SHALL be 0.
REQ-030 A write and a read of the same cell in the same cycle SHALL return the pre-write content, and the new content from the next cycle on.
REQ-031 clear_board asserted in any state SHALL abort the shot in progress with no result pulse and enter CLEAR.
REQ-032 clear_board asserted during CLEAR SHALL restart the sweep at index 0.

Reset
REQ-033 On rst the block SHALL enter CLEAR with sweep index 0.
REQ-034 On rst the outputs SHALL be: shot_ready=0, res_valid=0, res_hit=0, res_dup=0, res_err=0, ship_query_xy=0, hit_pixels=0, hit_count=0, game_over=0.
REQ-035 rst SHALL take priority over clear_board and over any handshake.
REQ-036 rst asserted mid-shot SHALL drop the shot with no res_valid pulse.

Verification
REQ-037 Reset then wait: shot_ready=0 for 100 cycles then 1, and every rd_xy 0..99 returns 0.
REQ-038 Shot (3,4) with ship_present=1: ship_query_xy=43, and res_valid with res_hit=1 comes 2 cycles after the handshake; hit_count=1; rd_xy=43, rd_line=0 returns 32'hC0000003.
REQ-039 Shot (3,4) repeated: res_dup=1 and res_hit=1, and hit_count stays 1. Shot (0,0) with ship_present=0: rd_xy=0, rd_line=7 returns 32'h0003C000.
REQ-040 Shot (10,2): res_valid with res_err=1 one cycle after the handshake, no cell written, and ship_query_xy stays 0.
REQ-041 17 distinct hit shots: game_over rises the cycle after the 17th hit is counted; a following clear_board resets hit_count=0 and game_over=0 and all cells read 0.
REQ-042 clear_board in LOOKUP: no res_valid pulse, shot_ready=0 for 100 cycles, and the target cell stays 00.

Source files
------------

// File: rtl/hit_map_ctrl.sv
// Battleship hit map: 100 two-bit cells updated by a shot FSM, plus an
// independent registered glyph read port for the renderer.
module hit_map_ctrl #(
    parameter int SHIP_CELLS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_board,
    input  logic        shot_valid,
    output logic        shot_ready,
    input  logic [3:0]  shot_x,
    input  logic [3:0]  shot_y,
    output logic [6:0]  ship_query_xy,
    input  logic        ship_present,
    output logic        res_valid,
    output logic        res_hit,
    output logic        res_dup,
    output logic        res_err,
    input  logic [6:0]  rd_xy,
    input  logic [4:0]  rd_line,
    output logic [31:0] hit_pixels,
    output logic [6:0]  hit_count,
    output logic        game_over,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_LOOKUP = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_MISS  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b11;
    localparam logic [6:0] LAST_CELL  = 7'd99;
    localparam logic [6:0] COUNT_MAX  = 7'h7f;

    state_t      state;
    state_t      state_next;

    logic [1:0]  cells [0:99];
    logic [6:0]  clr_idx;
    logic [3:0]  tgt_x;
    logic [3:0]  tgt_y;
    logic        tgt_err;
    logic [6:0]  tgt_idx;
    logic [1:0]  tgt_cell;
    logic        abort;
    logic        shot_fire;
    logic        shot_bad;

    logic        cell_we;
    logic [6:0]  cell_waddr;
    logic [1:0]  cell_wdata;
    logic        hit_inc;

    logic [1:0]  rd_cell;
    logic [3:0]  rd_row;
    logic [4:0]  rd_shift;
    logic [31:0] rd_pixels;
    logic        unused_rd_line;

    // Handshake: a shot is taken on a cycle where shot_valid and shot_ready
    // are both high; shot_ready is low whenever rst or clear_board would
    // discard the shot, so a seen ready always means the shot was accepted.
    assign abort     = rst | clear_board;
    assign shot_fire = shot_valid & shot_ready;
    assign shot_bad  = (shot_x > 4'd9) | (shot_y > 4'd9);
    assign tgt_idx   = 7'(tgt_y) * 7'd10 + 7'(tgt_x);
    assign tgt_cell  = (tgt_idx <= LAST_CELL) ? cells[tgt_idx] : CELL_EMPTY;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear_board) begin
            state_next = S_CLEAR;
        end else begin
            case (state)
                S_CLEAR:  if (clr_idx == LAST_CELL) state_next = S_IDLE;
                S_IDLE:   if (shot_fire) state_next = shot_bad ? S_UPDATE : S_LOOKUP;
                S_LOOKUP: state_next = S_UPDATE;
                S_UPDATE: state_next = S_IDLE;
                default:  state_next = S_CLEAR;
            endcase
        end
    end

    always_comb begin
        shot_ready    = 1'b0;
        ship_query_xy = 7'd0;
        res_valid     = 1'b0;
        res_hit       = 1'b0;
        res_dup       = 1'b0;
        res_err       = 1'b0;
        cell_we       = 1'b0;
        cell_waddr    = clr_idx;
        cell_wdata    = CELL_EMPTY;
        hit_inc       = 1'b0;
        case (state)
            S_CLEAR: begin
                cell_we = ~abort;
            end
            S_IDLE: begin
                shot_ready = ~abort;
            end
            S_LOOKUP: begin
                ship_query_xy = tgt_idx;
            end
            S_UPDATE: begin
                // An abort landing on the result cycle swallows both the pulse and the write.
                if (!abort) begin
                    res_valid = 1'b1;
                    if (tgt_err) begin
                        res_err = 1'b1;
                    end else if (tgt_cell != CELL_EMPTY) begin
                        res_dup = 1'b1;
                        res_hit = (tgt_cell == CELL_HIT);
                    end else begin
                        res_hit    = ship_present;
                        cell_we    = 1'b1;
                        cell_waddr = tgt_idx;
                        cell_wdata = ship_present ? CELL_HIT : CELL_MISS;
                        hit_inc    = ship_present;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            clr_idx <= 7'd0;
        end else if (state == S_CLEAR && clr_idx != LAST_CELL) begin
            clr_idx <= clr_idx + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_x   <= 4'd0;
            tgt_y   <= 4'd0;
            tgt_err <= 1'b0;
        end else if (shot_fire) begin
            tgt_x   <= shot_x;
            tgt_y   <= shot_y;
            tgt_err <= shot_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (abort) begin
            hit_count <= 7'd0;
            game_over <= 1'b0;
        end else begin
            if (hit_inc && hit_count != COUNT_MAX) begin
                hit_count <= hit_count + 7'd1;
            end
            game_over <= (32'(hit_count) >= 32'(SHIP_CELLS));
        end
    end

    always_ff @(posedge clk) begin
        if (cell_we) begin
            cells[cell_waddr] <= cell_wdata;
        end
    end

    // Glyph rows only use the low four bits of rd_line.
    assign unused_rd_line = rd_line[4];
    assign rd_row         = rd_line[3:0];
    assign rd_shift       = {rd_row, 1'b0};
    assign rd_cell        = (rd_xy <= LAST_CELL) ? cells[rd_xy] : CELL_EMPTY;

    always_comb begin
        rd_pixels = 32'd0;
        case (rd_cell)
            CELL_HIT:  rd_pixels = (32'h3 << rd_shift) | (32'h3 << (5'd30 - rd_shift));
            CELL_MISS: if (rd_row >= 4'd6 && rd_row <= 4'd9) rd_pixels = 32'h0003_C000;
            default:   rd_pixels = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_pixels <= 32'd0;
        end else begin
            hit_pixels <= rd_pixels;
        end
    end

endmodule

// File: tb/tb_hit_map_ctrl.sv
// Directed bench for hit_map_ctrl: a driver issues shots and queues the
// expected result; a monitor checks each result pulse against that queue.
module tb_hit_map_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_board = 1'b0;
    logic        shot_valid = 1'b0;
    logic        shot_ready;
    logic [3:0]  shot_x = 4'd0;
    logic [3:0]  shot_y = 4'd0;
    logic [6:0]  ship_query_xy;
    logic        ship_present = 1'b0;
    logic        res_valid;
    logic        res_hit;
    logic        res_dup;
    logic        res_err;
    logic [6:0]  rd_xy = 7'd0;
    logic [4:0]  rd_line = 5'd0;
    logic [31:0] hit_pixels;
    logic [6:0]  hit_count;
    logic        game_over;
    logic [1:0]  fsm_state;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        ship_map [0:99];
    logic [34:0] exp_q [$];

    hit_map_ctrl #(.SHIP_CELLS(17)) dut (
        .clk(clk), .rst(rst), .clear_board(clear_board),
        .shot_valid(shot_valid), .shot_ready(shot_ready),
        .shot_x(shot_x), .shot_y(shot_y),
        .ship_query_xy(ship_query_xy), .ship_present(ship_present),
        .res_valid(res_valid), .res_hit(res_hit), .res_dup(res_dup), .res_err(res_err),
        .rd_xy(rd_xy), .rd_line(rd_line), .hit_pixels(hit_pixels),
        .hit_count(hit_count), .game_over(game_over), .fsm_state(fsm_state)
    );

    // Clock, cycle counter and a one-cycle-latency ship map ROM.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        ship_present <= (ship_query_xy <= 7'd99) ? ship_map[ship_query_xy] : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples late in the low phase, after the drivers have settled.
    always @(negedge clk) begin
        logic [34:0] e;
        #2;
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%b%b%b required=none (t=%0t)",
                         res_hit, res_dup, res_err, $time);
            end else begin
                e = exp_q.pop_front();
                check("res_flags", {29'd0, res_hit, res_dup, res_err}, {29'd0, e[2:0]});
                check("res_latency", cyc, e[34:3]);
            end
        end else begin
            check("idle_flags", {29'd0, res_hit, res_dup, res_err}, 32'd0);
        end
    end

    task automatic send_shot(input int x, input int y, input bit eh, input bit ed,
                             input bit ee, input bit expect_res);
        int waits;
        int exp_q_xy;
        waits = 0;
        @(negedge clk);
        shot_x = 4'(x);
        shot_y = 4'(y);
        shot_valid = 1'b1;
        #1;
        while (!shot_ready && waits < 400) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("shot_accept", {31'd0, shot_ready}, 32'd1);
        if (shot_ready && expect_res) begin
            exp_q.push_back({32'(cyc + (ee ? 1 : 2)), eh, ed, ee});
        end
        @(negedge clk);
        shot_valid = 1'b0;
        #1;
        exp_q_xy = ee ? 0 : (y * 10 + x);
        check("query_xy", {25'd0, ship_query_xy}, 32'(exp_q_xy));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!shot_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, shot_ready}, 32'd1);
    endtask

    // Called at the negedge where rst/clear_board was just dropped.
    task automatic count_not_ready();
        int n;
        n = 0;
        #1;
        while (!shot_ready && n < 300) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("clear_cycles", n, 32'd100);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
        count_not_ready();
    endtask

    task automatic read_check(input string name, input int xy, input int line,
                              input logic [31:0] exp);
        @(negedge clk);
        rd_xy = 7'(xy);
        rd_line = 5'(line);
        @(negedge clk);
        #1;
        check(name, hit_pixels, exp);
    endtask

    initial begin
        for (int i = 0; i < 100; i++) ship_map[i] = 1'b0;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, shot_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_query", {25'd0, ship_query_xy}, 32'd0);
        check("rst_pixels", hit_pixels, 32'd0);
        check("rst_hit_count", {25'd0, hit_count}, 32'd0);
        check("rst_game_over", {31'd0, game_over}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        count_not_ready();
        for (int i = 0; i < 100; i++) read_check("reset_cell", i, i % 16, 32'd0);

        // Fresh hit, duplicate hit, miss, duplicate miss.
        ship_map[43] = 1'b1;
        send_shot(3, 4, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_idle();
        check("hit_count_1", {25'd0, hit_count}, 32'd1);
        read_check("hit_glyph_r0", 43, 0, 32'hC000_0003);
        read_check("hit_glyph_r5", 43, 5, 32'h0030_0C00);
        send_shot(3, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle();
        check("dup_hit_count", {25'd0, hit_count}, 32'd1);
        send_shot(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        read_check("miss_glyph_r7", 0, 7, 32'h0003_C000);
        read_check("miss_glyph_r5", 0, 5, 32'd0);
        read_check("miss_glyph_line22", 0, 22, 32'h0003_C000);
        send_shot(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle();
        check("miss_hit_count", {25'd0, hit_count}, 32'd1);

        // Off-board shots.
        send_shot(10, 2, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle();
        send_shot(5, 12, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_idle();
        check("err_hit_count", {25'd0, hit_count}, 32'd1);
        read_check("err_no_write", 30, 0, 32'd0);
        read_check("rd_out_of_range", 120, 0, 32'd0);

        // Read of a cell in the same cycle it is written sees the old value.
        ship_map[77] = 1'b1;
        read_check("rw_before", 77, 0, 32'd0);
        send_shot(7, 7, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        check("rw_update_cycle", hit_pixels, 32'd0);
        @(negedge clk); #1;
        check("rw_write_cycle", hit_pixels, 32'd0);
        @(negedge clk); #1;
        check("rw_after", hit_pixels, 32'hC000_0003);
        check("hit_count_2", {25'd0, hit_count}, 32'd2);

        // Game over after 17 distinct hits.
        clear_pulse();
        check("clr_hit_count", {25'd0, hit_count}, 32'd0);
        for (int i = 0; i < 17; i++) ship_map[i * 5] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_shot((i * 5) % 10, (i * 5) / 10, 1'b1, 1'b0, 1'b0, 1'b1);
            wait_idle();
        end
        check("hit_count_16", {25'd0, hit_count}, 32'd16);
        check("game_over_16", {31'd0, game_over}, 32'd0);
        send_shot(0, 8, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("hit_count_17", {25'd0, hit_count}, 32'd17);
        check("game_over_lag", {31'd0, game_over}, 32'd0);
        @(negedge clk); #1;
        check("game_over_17", {31'd0, game_over}, 32'd1);
        read_check("hit_glyph_cell5", 5, 5, 32'h0030_0C00);
        clear_pulse();
        check("wipe_hit_count", {25'd0, hit_count}, 32'd0);
        check("wipe_game_over", {31'd0, game_over}, 32'd0);
        for (int i = 0; i < 100; i++) read_check("wiped_cell", i, 0, 32'd0);

        // Aborts: clear in LOOKUP, clear in UPDATE, rst in LOOKUP.
        ship_map[22] = 1'b1;
        send_shot(2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
        count_not_ready();
        read_check("abort_lookup_cell", 22, 0, 32'd0);
        check("abort_lookup_count", {25'd0, hit_count}, 32'd0);
        send_shot(2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        clear_board = 1'b1;
        @(negedge clk);
        clear_board = 1'b0;
        count_not_ready();
        check("abort_update_count", {25'd0, hit_count}, 32'd0);
        send_shot(2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_not_ready();
        read_check("abort_rst_cell", 22, 0, 32'd0);

        // Still functional afterwards: corner miss.
        send_shot(9, 9, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        read_check("corner_miss_r8", 99, 8, 32'h0003_C000);
        read_check("corner_miss_r10", 99, 10, 32'd0);

        repeat (4) @(negedge clk);
        check("pending_results", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
